// File: rtl/rst_sync.sv
// rst_sync: reset synchronizer for one clock domain.
// Asserts SYNC_RST (active-low) asynchronously when RST falls and
// releases it synchronously to CLK after NUM_STAGES rising edges.
// Optional build macro RST_SYNC_STRETCH_EN adds parameter STRETCH_CYCLES
// and holds SYNC_RST low for that many extra edges after the chain fills.
module rst_sync #(
  parameter int unsigned NUM_STAGES     = 2
`ifdef RST_SYNC_STRETCH_EN
  ,
  parameter int unsigned STRETCH_CYCLES = 4
`endif
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_RST
);

  localparam int unsigned MSB = NUM_STAGES - 1;

  // Reject chain lengths that give either no metastability margin or
  // needlessly long release latency.
  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_stages
    $error("rst_sync: NUM_STAGES must be in 2..8");
  end

  // Adjacent placement and no retiming: these flops resolve metastability.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  // Shift a constant one into the chain; the tail flop sees it last.
  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], 1'b1};
  end

  // Chain clears the instant RST falls, independent of CLK.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef RST_SYNC_STRETCH_EN

  if (STRETCH_CYCLES < 1 || STRETCH_CYCLES > 255) begin : g_bad_stretch
    $error("rst_sync: STRETCH_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(STRETCH_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       out_q;
  logic       out_d;

  // Count edges after the chain releases; release output on the last one.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (sync_q[MSB] && !out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Stretch counter and output flop share the asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= 8'd0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign SYNC_RST = out_q;

`else

  // Output is taken straight from the tail flop, no logic in between.
  assign SYNC_RST = sync_q[MSB];

`endif

endmodule

// File: tb/tb_rst_sync.sv
// Directed bench for rst_sync: four instances (2, 3, 4, 8 stages) share
// one clock and reset; each edge checks every output against its latency.
`timescale 1ns/1ps
module tb_rst_sync;

`ifdef RST_SYNC_STRETCH_EN
  localparam int STR = 4;
`else
  localparam int STR = 0;
`endif

  logic CLK;
  logic RST;
  logic [3:0] sr;

  int checks   = 0;
  int failures = 0;

`ifdef RST_SYNC_STRETCH_EN
  rst_sync #(.NUM_STAGES(2), .STRETCH_CYCLES(4)) u_s2 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[0]));
  rst_sync #(.NUM_STAGES(3), .STRETCH_CYCLES(4)) u_s3 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[1]));
  rst_sync #(.NUM_STAGES(4), .STRETCH_CYCLES(4)) u_s4 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[2]));
  rst_sync #(.NUM_STAGES(8), .STRETCH_CYCLES(4)) u_s8 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[3]));
`else
  rst_sync #(.NUM_STAGES(2)) u_s2 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[0]));
  rst_sync #(.NUM_STAGES(3)) u_s3 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[1]));
  rst_sync #(.NUM_STAGES(4)) u_s4 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[2]));
  rst_sync #(.NUM_STAGES(8)) u_s8 (.CLK(CLK), .RST(RST), .SYNC_RST(sr[3]));
`endif

  // 40 ns period, first rising edge at 20 ns.
  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  function automatic int lat(input int i);
    case (i)
      0:       lat = 2 + STR;
      1:       lat = 3 + STR;
      2:       lat = 4 + STR;
      default: lat = 8 + STR;
    endcase
  endfunction

  task automatic check(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d t=%0t observed=%b expected=%b", tag, idx, $time, obs, exp);
    end
  endtask

  // k = release edges seen so far; output is high once k reaches latency.
  task automatic check_all(input string tag, input int k);
    for (int i = 0; i < 4; i++) begin
      check(tag, i, sr[i], (k >= lat(i)) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic release_run(input string tag);
    for (int k = 1; k <= 13; k++) begin
      @(posedge CLK);
      #1;
      check_all(tag, k);
    end
  endtask

  initial begin
    RST = 1'b0;
    #1;
    check_all("reset_state", 0);
    #1;
    RST = 1'b1;                      // release at t=2
    release_run("release");          // edges 20, 60, 100, ...

    // Steady state: mid-cycle assertion is visible with no clock edge.
    #20;
    RST = 1'b0;
    #1;
    check_all("async_assert", 0);

    // Release, then reassert after one edge: chain must restart.
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_all("partial_release", 1);
    #2;
    RST = 1'b0;
    #1;
    check_all("mid_release_assert", 0);
    RST = 1'b1;
    release_run("restart");

    // 1 ns glitch between edges in steady state.
    #20;
    RST = 1'b0;
    #1;
    RST = 1'b1;
    #0.5;
    check_all("glitch_capture", 0);
    release_run("glitch_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
